// File: rtl/i2s_audio_rx.sv
// i2s_audio_rx: I2S serial receiver producing parallel 16-bit stereo samples in the clk32 domain.
// Ports:
//   clk32        system clock (only clock)
//   reset_n      synchronous active-low reset
//   i2s_bclk     serial bit clock (async)
//   i2s_lrck     word select (async), 0 = left, 1 = right
//   i2s_din      serial data (async), changes on bclk rising edge
//   audio_l/r    last complete left/right sample, BITS captured bits left-aligned
//   audio_valid  one-cycle pulse when audio_l/audio_r update
//   locked       high while aligned to frames
//   frame_err    sticky short-half-frame flag
// Build option: define I2S_RX_PHILIPS_EN for Philips framing (MSB one bclk after lrck change);
// default is left-justified framing (MSB on the lrck change edge).
module i2s_audio_rx #(
  parameter int unsigned BITS        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk32,
  input  logic        reset_n,
  input  logic        i2s_bclk,
  input  logic        i2s_lrck,
  input  logic        i2s_din,
  output logic [15:0] audio_l,
  output logic [15:0] audio_r,
  output logic        audio_valid,
  output logic        locked,
  output logic        frame_err
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   bclk_d;
  logic                   lrck_prev;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [W-1:0]           shreg;
  logic [W-1:0]           hold;

  logic          bclk_s_c, lrck_s_c, din_s_c;
  logic          fall_c, lr_edge_c, short_c;
  logic [W-1:0]  sh_start_c;
  logic [CW-1:0] cnt_start_c;

  // Synchronized pin views, edge and framing decodes
  assign bclk_s_c  = bclk_sync[SYNC_STAGES-1];
  assign lrck_s_c  = lrck_sync[SYNC_STAGES-1];
  assign din_s_c   = din_sync[SYNC_STAGES-1];
  assign fall_c    = bclk_d & ~bclk_s_c;
  assign lr_edge_c = lrck_s_c ^ lrck_prev;
  assign short_c   = (cnt < CW'(BITS));

  // Shift register / counter contents on entering a half-frame
`ifdef I2S_RX_PHILIPS_EN
  // Bit sampled with the lrck change is the stale bit of the previous word
  assign sh_start_c  = '0;
  assign cnt_start_c = '0;
`else
  // Bit sampled with the lrck change is the MSB
  assign sh_start_c  = {din_s_c, {(W-1){1'b0}}};
  assign cnt_start_c = CW'(1);
`endif

  // Synchronizers, edge detect and framing FSM
  always_ff @(posedge clk32) begin
    if (!reset_n) begin
      bclk_sync   <= '0;
      lrck_sync   <= '0;
      din_sync    <= '0;
      bclk_d      <= 1'b0;
      lrck_prev   <= 1'b0;
      state       <= HUNT;
      cnt         <= '0;
      shreg       <= '0;
      hold        <= '0;
      audio_l     <= '0;
      audio_r     <= '0;
      audio_valid <= 1'b0;
      locked      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      bclk_sync   <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sync   <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
      din_sync    <= {din_sync[SYNC_STAGES-2:0], i2s_din};
      bclk_d      <= bclk_s_c;
      audio_valid <= 1'b0;
      if (fall_c) begin
        lrck_prev <= lrck_s_c;
        case (state)
          HUNT: begin
            if (lrck_prev && !lrck_s_c) begin
              state  <= LEFT;
              locked <= 1'b1;
              shreg  <= sh_start_c;
              cnt    <= cnt_start_c;
            end
          end
          LEFT, RIGHT: begin
            if (lr_edge_c) begin
              if (short_c) begin
                // Short half-frame: drop the pending frame and re-hunt
                frame_err <= 1'b1;
                locked    <= 1'b0;
                state     <= HUNT;
              end else begin
                shreg <= sh_start_c;
                cnt   <= cnt_start_c;
                if (state == LEFT) begin
                  hold  <= shreg;
                  state <= RIGHT;
                end else begin
                  audio_l     <= hold;
                  audio_r     <= shreg;
                  audio_valid <= 1'b1;
                  state       <= LEFT;
                end
              end
            end else if (short_c) begin
              // Bits beyond BITS in a slot are ignored
              shreg[4'(5'd15 - cnt)] <= din_s_c;
              cnt                    <= cnt + CW'(1);
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
